bus_dma_master: RTL and testbench
=================================

Name: bus_dma_master

Overview:
- Single-channel copy engine. It is the master that sits directly upstream of the BUS block and drives its master port (m_req/m_wr/m_addr/m_dout, receives m_grant/m_din).
- Once started with source, destination and length, it requests the bus, copies `length` 64-bit signed words one at a time (read from src, write to dst), releases the bus and pulses done.
- Typical use: moving data between slave 0 (0x0000–0x07FF) and slave 1 (0x7000–0x71FF).

Parameters:
- RD_LAT, 1, cycles from the read address cycle until m_din is valid; legal range 1–3.
- LEN_W, 9, width of the length field; max transfer is 2^LEN_W−1 words.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle start strobe; sampled only in IDLE.
- src_addr  input  16  first source word address; latched on accepted start.
- dst_addr  input  16  first destination word address; latched on accepted start.
- length  input  LEN_W  number of words to copy; latched on accepted start.
- busy  output  1  high from accepted start until the DONE cycle inclusive.
- done  output  1  one-cycle pulse when the transfer completes.
- m_req  output  1  bus request to the BUS block.
- m_wr  output  1  1 = write cycle, 0 = read cycle.
- m_addr  output  16  bus address.
- m_dout  output  64  signed write data.
- m_grant  input  1  bus grant from the BUS block.
- m_din  input  64  signed read data from the BUS block.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - busy, done, m_req, m_wr = 0; m_addr = 16'h0; m_dout = 64'h0.
  - Internal pointers, word counter, data buffer and latency counter = 0.
  - Reset asserted mid-transfer aborts it immediately; no done pulse.
- States: IDLE, REQ, RD, WAIT, WR, DONE. All outputs are registered.
- IDLE:
  - start=1 and length≠0: latch src/dst/length, counter=0, go to REQ.
  - start=1 and length=0: go straight to DONE (done pulse, no bus activity).
  - start while busy is ignored.
- REQ: m_req=1, m_wr=0. On m_grant=1 go to RD.
- RD (1 cycle):
  - m_req=1, m_wr=0, m_addr=src_ptr. Go to WAIT with latency counter = RD_LAT.
- WAIT:
  - m_addr holds src_ptr, m_wr=0.
  - Latency counter decrements each cycle; on the cycle it reaches 1, capture m_din into the buffer and go to WR.
- WR (1 cycle):
  - m_wr=1, m_addr=dst_ptr, m_dout=buffer.
  - Next: src_ptr+1, dst_ptr+1, counter+1.
  - If counter+1 == length go to DONE, else go to RD.
- DONE (1 cycle):
  - done=1, busy=1, m_req=0, m_wr=0; m_addr/m_dout hold their last values. Then go to IDLE (busy=0).
- Throughput: 2+RD_LAT cycles per word after grant.
- Total latency from accepted start to the done cycle, with grant held high: 1 + N·(2+RD_LAT) + 1 cycles.
- m_wr is high only in the WR state.
- Address arithmetic is 16-bit modulo: 0xFFFF+1 wraps to 0x0000 silently. Address-map legality is not checked.
- Data is passed through unmodified (signed 64-bit, no extension or truncation).
- Grant loss (m_grant=0 in RD/WAIT/WR):
  - m_req stays 1, m_wr forced 0, no capture or advance; the FSM returns to REQ.
  - On re-grant the current word restarts from RD; a word already written is never rewritten.
- m_grant high in IDLE or DONE is ignored.

Test Plan:
- Reset check: reset_n=0 at t=0, released at 17ns → all outputs 0, state IDLE, m_req stays 0 with no start.
- Basic copy: src=0x0001, dst=0x7000, length=3, grant held 1, RD_LAT=1, slave returns 1,2,3 → writes 0x7000←1, 0x7001←2, 0x7002←3; done pulses exactly 11 cycles after start; m_req low in the done cycle.
- Zero length: start with length=0 → done pulses next cycle, m_req never asserts.
- Grant stall: grant delayed 4 cycles after m_req, then dropped 1 cycle during the second word's WAIT → second word re-read from src+1, each dst written exactly once, correct data.
- Wrap and signed data: src=0xFFFF, length=2, data 64'hFFFF_FFFF_FFFF_FFFE → reads 0xFFFF then 0x0000; m_dout equals the read values bit-exact.
- Abort and ignore: second start pulsed mid-transfer → ignored; reset_n pulled low mid-WR → all outputs 0 asynchronously, no done.

Source files
------------

// File: rtl/bus_dma_master.sv
// bus_dma_master: single-channel copy engine. It masters the BUS block:
// it requests the bus, then copies `length` 64-bit words one at a time
// (read from the source pointer, then write to the destination pointer),
// releases the bus and pulses done.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset (aborts any transfer, no done)
//   start     one-cycle start strobe, sampled only in IDLE
//   src_addr  first source word address (latched on accepted start)
//   dst_addr  first destination word address (latched on accepted start)
//   length    number of words to copy (latched on accepted start)
//   busy      high from accepted start through the DONE cycle
//   done      one-cycle completion pulse
//   m_req     bus request
//   m_wr      1 = write cycle, 0 = read cycle
//   m_addr    bus address
//   m_dout    write data
//   m_grant   bus grant
//   m_din     read data, valid RD_LAT cycles after the read address cycle
module bus_dma_master #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned LEN_W  = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             m_req,
  output logic             m_wr,
  output logic [15:0]      m_addr,
  output logic [63:0]      m_dout,
  input  logic             m_grant,
  input  logic [63:0]      m_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  state_t           state;
  logic [15:0]      src_ptr;
  logic [15:0]      dst_ptr;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [1:0]       lat;
  logic [63:0]      buffer;

  // The capture register is the write-data register: it is loaded at the end
  // of WAIT, presented during WR and simply holds afterwards.
  assign m_dout  = buffer;
  assign cnt_nxt = cnt + LEN_W'(1);

  // Outputs are registered: each transition loads the values belonging to the
  // state being entered. Any grant loss in RD/WAIT/WR falls back to REQ
  // without capturing or advancing, so the current word restarts from RD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_req   <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      buffer  <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      len_q   <= '0;
      cnt     <= '0;
      lat     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              src_ptr <= src_addr;
              dst_ptr <= dst_addr;
              len_q   <= length;
              cnt     <= '0;
              m_req   <= 1'b1;
              m_wr    <= 1'b0;
              state   <= S_REQ;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_REQ: begin
          if (m_grant) begin
            m_addr <= src_ptr;
            state  <= S_RD;
          end
        end

        S_RD: begin
          if (!m_grant) begin
            state <= S_REQ;
          end else begin
            lat   <= LAT_INIT;
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!m_grant) begin
            state <= S_REQ;
          end else if (lat == 2'd1) begin
            buffer <= m_din;
            m_wr   <= 1'b1;
            m_addr <= dst_ptr;
            state  <= S_WR;
          end else begin
            lat <= lat - 2'd1;
          end
        end

        S_WR: begin
          m_wr <= 1'b0;
          if (!m_grant) begin
            state <= S_REQ;
          end else begin
            src_ptr <= src_ptr + 16'd1;
            dst_ptr <= dst_ptr + 16'd1;
            cnt     <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              m_req <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              m_addr <= src_ptr + 16'd1;
              state  <= S_RD;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          m_req <= 1'b0;
          m_wr  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Testbench for bus_dma_master: a slave memory model answers reads one cycle
// after the address; expected writes are queued when a transfer is started and
// consumed by a write monitor as the DUT writes.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [logic [15:0]];
  logic [15:0] sb_addr [$];
  logic [63:0] sb_data [$];
  bit          sb_en = 1'b1;
  int          done_cnt = 0;
  int          req_cnt = 0;

  bus_dma_master #(.RD_LAT(1), .LEN_W(9)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .length  (length),
    .busy    (busy),
    .done    (done),
    .m_req   (m_req),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_dout  (m_dout),
    .m_grant (m_grant),
    .m_din   (m_din)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hA5A5, a, ~a, a};
  endfunction

  // Slave: read data valid one cycle after the address is presented.
  always @(posedge clk) m_din <= rd(m_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    int pending;
    forever begin
      @(negedge clk);
      if (reset_n && done) done_cnt++;
      if (reset_n && m_req) req_cnt++;
      if (reset_n && sb_en && m_req && m_grant && m_wr) begin
        pending = sb_addr.size();
        chk("wr_expected", 64'(pending != 0), 64'd1);
        if (pending != 0) begin
          chk("wr_addr", 64'(m_addr), 64'(sb_addr.pop_front()));
          chk("wr_data", m_dout, sb_data.pop_front());
        end
      end
    end
  endtask

  task automatic kick(input logic [15:0] s, input logic [15:0] d,
                      input logic [8:0] n, input bit push);
    logic [15:0] a;
    if (push) begin
      for (int i = 0; i < int'(n); i++) begin
        a = s + 16'(i);
        sb_addr.push_back(d + 16'(i));
        sb_data.push_back(rd(a));
      end
    end
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; length = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Call right after kick: cycle 1 is the cycle after the start cycle.
  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    int cyc;
    int d0;
    int r0;
    bit found;

    fork
      monitor();
    join_none

    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    m_grant = 1'b0;
    mem[16'h0001] = 64'd1;
    mem[16'h0002] = 64'd2;
    mem[16'h0003] = 64'd3;
    mem[16'hFFFF] = 64'hFFFF_FFFF_FFFF_FFFE;
    mem[16'h0000] = 64'h8000_0000_0000_0003;

    // Reset
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(m_req), 64'd0);
    chk("rst_wr", 64'(m_wr), 64'd0);
    chk("rst_addr", 64'(m_addr), 64'd0);
    chk("rst_dout", m_dout, 64'd0);
    #16 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_req", 64'(m_req), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Basic copy, grant held
    m_grant = 1'b1;
    kick(16'h0001, 16'h7000, 9'd3, 1'b1);
    chk("basic_busy", 64'(busy), 64'd1);
    wait_done(40, cyc);
    chk("basic_latency", 64'(cyc), 64'd11);
    chk("basic_req_done", 64'(m_req), 64'd0);
    chk("basic_busy_done", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("basic_done_pulse", 64'(done), 64'd0);
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_sb_empty", 64'(sb_addr.size()), 64'd0);

    // Zero length
    r0 = req_cnt;
    kick(16'h0005, 16'h7005, 9'd0, 1'b1);
    wait_done(5, cyc);
    chk("zero_latency", 64'(cyc), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_no_req", 64'(req_cnt - r0), 64'd0);

    // Grant stall: late grant, then dropped during second word's WAIT
    m_grant = 1'b0;
    kick(16'h0010, 16'h7010, 9'd3, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_req) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("stall_req_seen", 64'(found), 64'd1);
    repeat (4) @(posedge clk);
    #1 m_grant = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (m_req && !m_wr && m_addr == 16'h0011) found = 1'b1;
    end
    chk("stall_rd2_seen", 64'(found), 64'd1);
    @(posedge clk); #1 m_grant = 1'b0;
    @(posedge clk); #1 m_grant = 1'b1;
    chk("stall_req_held", 64'(m_req), 64'd1);
    chk("stall_wr_low", 64'(m_wr), 64'd0);
    wait_done(60, cyc);
    chk("stall_sb_empty", 64'(sb_addr.size()), 64'd0);

    // Address wrap with negative data
    kick(16'hFFFF, 16'h7100, 9'd2, 1'b1);
    wait_done(40, cyc);
    chk("wrap_latency", 64'(cyc), 64'd8);
    chk("wrap_sb_empty", 64'(sb_addr.size()), 64'd0);

    // Second start mid-transfer is ignored
    kick(16'h0100, 16'h7020, 9'd4, 1'b1);
    repeat (3) @(posedge clk);
    #1 begin start = 1'b1; src_addr = 16'h0200; dst_addr = 16'h7040; length = 9'd5; end
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("ignore_done_seen", 64'(done), 64'd1);
    chk("ignore_sb_empty", 64'(sb_addr.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("ignore_idle", 64'(busy), 64'd0);

    // Reset pulled mid-WR
    sb_en = 1'b0;
    kick(16'h0300, 16'h7060, 9'd3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (m_wr) found = 1'b1;
    end
    chk("abort_wr_seen", 64'(found), 64'd1);
    d0 = done_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_req", 64'(m_req), 64'd0);
    chk("abort_wr", 64'(m_wr), 64'd0);
    chk("abort_addr", 64'(m_addr), 64'd0);
    chk("abort_dout", m_dout, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_idle_req", 64'(m_req), 64'd0);

    // Recovery after abort
    sb_en = 1'b1;
    kick(16'h0002, 16'h7003, 9'd1, 1'b1);
    wait_done(20, cyc);
    chk("recover_latency", 64'(cyc), 64'd5);
    chk("final_sb_empty", 64'(sb_addr.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
